// File: rtl/stim_seq_if.sv
// Bus bundle for stim_seq_player.
// Carries the step-table write port, the playback controls and the
// event outputs.
// master: the side that programs the table and starts playback.
// slave : the player itself.
interface stim_seq_if #(
   parameter int AW    = 4,
   parameter int DLY_W = 12
);
   logic              cfg_we;
   logic [AW-1:0]     cfg_addr;
   logic [DLY_W+2:0]  cfg_data;
   logic [AW:0]       cfg_len;
   logic              start;
   logic              abort;
   logic [3:0]        sig_out;
   logic [AW-1:0]     step_idx;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output cfg_we, cfg_addr, cfg_data, cfg_len, start, abort,
      input  sig_out, step_idx, busy, done, err
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, cfg_len, start, abort,
      output sig_out, step_idx, busy, done, err
   );
endinterface

// File: rtl/stim_seq_player.sv
// stim_seq_player: programmable event-sequence generator for the i1..i4
// inputs of the sequence-detector FSMs.
// Each table entry holds {channel[1:0], level, delay[DLY_W-1:0]}.
// During playback every step waits 'delay' cycles and then drives
// sig_out[channel] to 'level'.
// A step with delay d applies d+1 cycles after the previous event.
//
// Optional build macro SEQ_LOOP_EN adds a 'loop' input. While it is high,
// playback wraps from the last step back to step 0 instead of finishing.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; table writable; sig_out holds last value
// S_WAIT | timing the current step; applies it when the counter is zero
// S_DONE | single cycle after the last step (done pulse visible)
module stim_seq_player #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DLY_W = 12
) (
   input  logic         clk,
   input  logic         reset,
`ifdef SEQ_LOOP_EN
   input  logic         loop,
`endif
   stim_seq_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   logic [DLY_W+2:0] tbl_q [DEPTH];

   state_t           state_q, state_d;
   logic [3:0]       sig_q, sig_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [DLY_W-1:0] cnt_q, cnt_d;
   logic [AW:0]      len_q, len_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [1:0]       cur_ch;
   logic             cur_lvl;
   logic [DLY_W-1:0] first_dly;
   logic [DLY_W-1:0] next_dly;
   logic             len_ok;
   logic             is_last;
   logic             do_wrap;

   assign cur_ch    = tbl_q[idx_q][DLY_W+2:DLY_W+1];
   assign cur_lvl   = tbl_q[idx_q][DLY_W];
   assign first_dly = tbl_q[0][DLY_W-1:0];
   // Only consulted when the current step is not the last, so the index
   // never wraps into an entry outside the played range.
   assign next_dly  = tbl_q[idx_q + AW'(1)][DLY_W-1:0];

   assign len_ok  = (bus.cfg_len != '0) && (bus.cfg_len <= (AW+1)'(DEPTH));
   assign is_last = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));

`ifdef SEQ_LOOP_EN
   assign do_wrap = loop;
`else
   assign do_wrap = 1'b0;
`endif

   // Table write port; blocked during playback so a running sequence
   // can never be altered under its own feet.
   always_ff @(posedge clk) begin
      if (bus.cfg_we && !busy_q) begin
         tbl_q[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   // Next-state and next-output logic of the playback FSM.
   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            // abort wins over start and suppresses the error pulse too
            if (bus.start && !bus.abort) begin
               if (len_ok) begin
                  sig_d   = '0;
                  idx_d   = '0;
                  cnt_d   = first_dly;
                  len_d   = bus.cfg_len;
                  busy_d  = 1'b1;
                  state_d = S_WAIT;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         S_WAIT: begin
            if (bus.abort) begin
               state_d = S_IDLE;
               sig_d   = '0;
               busy_d  = 1'b0;
               idx_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DLY_W'(1);
            end else begin
               sig_d[cur_ch] = cur_lvl;
               if (is_last) begin
                  if (do_wrap) begin
                     idx_d = '0;
                     cnt_d = first_dly;
                  end else begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end
               end else begin
                  idx_d = idx_q + AW'(1);
                  cnt_d = next_dly;
               end
            end
         end

         S_DONE: begin
            // start is ignored here; a held start is taken on the next IDLE cycle
            state_d = S_IDLE;
            if (bus.abort) begin
               sig_d  = '0;
               busy_d = 1'b0;
               idx_d  = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
            sig_d   = '0;
            busy_d  = 1'b0;
            idx_d   = '0;
         end
      endcase
   end

   // FSM and output registers; synchronous reset, table left untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         sig_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.sig_out  = sig_q;
   assign bus.step_idx = idx_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_stim_seq_player.sv
// Testbench for stim_seq_player.
// The reference model keeps a copy of the step table and derives, for each
// playback, the absolute edge at which every step applies (running sum of
// delay+1). Expected outputs per cycle follow from that schedule.
module tb_stim_seq_player;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int DLY_W = 12;

   logic clk = 1'b0;
   logic reset;
`ifdef SEQ_LOOP_EN
   logic loop;
`endif

   stim_seq_if #(.AW(AW), .DLY_W(DLY_W)) bus ();

   stim_seq_player #(.DEPTH(DEPTH), .AW(AW), .DLY_W(DLY_W)) dut (
      .clk   (clk),
      .reset (reset),
`ifdef SEQ_LOOP_EN
      .loop  (loop),
`endif
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   bit [1:0] m_ch  [DEPTH];
   bit       m_lvl [DEPTH];
   int       m_dly [DEPTH];
   logic [3:0] sig_m = 4'h0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int addr, input int ch, input bit lvl, input int dly);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = AW'(addr);
      bus.cfg_data = {2'(ch), lvl, DLY_W'(dly)};
      tick();
      bus.cfg_we   = 1'b0;
      m_ch[addr]  = 2'(ch);
      m_lvl[addr] = lvl;
      m_dly[addr] = dly;
   endtask

   // Start a one-shot playback of 'len' steps and check every cycle
   // against the schedule. With poke set, try to overwrite entry 0 while busy.
   task automatic play(input int len, input bit poke);
      int t [DEPTH];
      int acc, k, t_last, busy_n, done_n;
      logic [3:0] s;
      acc = 0;
      for (int i = 0; i < len; i++) begin
         acc += m_dly[i] + 1;
         t[i] = acc;
      end
      t_last = t[len-1];
      bus.cfg_len = (AW+1)'(len);
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      if (poke) begin
         bus.cfg_we   = 1'b1;
         bus.cfg_addr = '0;
         bus.cfg_data = ~{m_ch[0], m_lvl[0], DLY_W'(m_dly[0])};
      end
      s = 4'h0; k = 0; busy_n = 0; done_n = 0;
      for (int n = 0; n <= t_last + 1; n++) begin
         if (n == 1) bus.cfg_we = 1'b0;
         while (k < len && t[k] == n) begin
            s[m_ch[k]] = m_lvl[k];
            k++;
         end
         chk("sig_out", 32'(bus.sig_out), 32'(s));
         chk("busy", 32'(bus.busy), 32'(n < t_last));
         chk("done", 32'(bus.done), 32'(n == t_last));
         if (n <= t_last)
            chk("step_idx", 32'(bus.step_idx), 32'((k < len) ? k : len - 1));
         if (bus.busy) busy_n++;
         if (bus.done) done_n++;
         tick();
      end
      chk("busy_cycles", 32'(busy_n), 32'(t_last));
      chk("done_pulses", 32'(done_n), 32'd1);
      sig_m = s;
   endtask

   task automatic bad_start(input int len);
      bus.cfg_len = (AW+1)'(len);
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("err_pulse", 32'(bus.err), 32'd1);
      chk("err_busy", 32'(bus.busy), 32'd0);
      chk("err_sig", 32'(bus.sig_out), 32'(sig_m));
      tick();
      chk("err_drop", 32'(bus.err), 32'd0);
      chk("err_busy2", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int chs [13];
      int lvs [13];
      int len;
      bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_len = '0;
      bus.start = 0; bus.abort = 0;
`ifdef SEQ_LOOP_EN
      loop = 0;
`endif
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_sig", 32'(bus.sig_out), 32'd0);
      chk("rst_idx", 32'(bus.step_idx), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);

      // Detector's accepted sequence, all delays 0
      chs = '{2, 0, 2, 3, 0, 1, 0, 3, 2, 3, 1, 0, 2};
      lvs = '{1, 1, 0, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0};
      for (int i = 0; i < 13; i++) wr(i, chs[i], lvs[i][0], 0);
      play(13, 0);

      // Delay 5 then delay 0
      wr(0, 0, 1'b1, 5);
      wr(1, 3, 1'b1, 0);
      play(2, 0);

      // Rejected starts
      bad_start(0);
      bad_start(17);

      // Abort during step 2's delay, then replay from step 0
      for (int i = 0; i < 4; i++) wr(i, i, 1'b1, 3);
      bus.cfg_len = 5'd4;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (9) tick();
      chk("pre_abort_idx", 32'(bus.step_idx), 32'd2);
      chk("pre_abort_sig", 32'(bus.sig_out), 32'h3);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abort_sig", 32'(bus.sig_out), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_idx", 32'(bus.step_idx), 32'd0);
      for (int i = 0; i < 8; i++) begin
         chk("abort_nodone", 32'(bus.done), 32'd0);
         chk("abort_idle", 32'(bus.busy), 32'd0);
         tick();
      end
      sig_m = 4'h0;
      play(4, 0);

      // Write while busy is ignored; replay shows original entry 0
      play(4, 1);
      play(4, 0);

      // start together with abort in IDLE
      bus.cfg_len = 5'd4;
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("sa_busy", 32'(bus.busy), 32'd0);
         chk("sa_err", 32'(bus.err), 32'd0);
         chk("sa_sig", 32'(bus.sig_out), 32'(sig_m));
         tick();
      end

      // Reset mid-playback keeps the table
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_sig", 32'(bus.sig_out), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_idx", 32'(bus.step_idx), 32'd0);
      sig_m = 4'h0;
      play(4, 0);

      // Randomized tables and lengths
      for (int r = 0; r < 20; r++) begin
         len = int'($urandom_range(DEPTH, 1));
         for (int i = 0; i < len; i++)
            wr(i, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
               int'($urandom_range(6, 0)));
         play(len, 0);
      end

`ifdef SEQ_LOOP_EN
      // Loop: two steps of delay 1 on channel 0, period 4 cycles
      wr(0, 0, 1'b1, 1);
      wr(1, 0, 1'b0, 1);
      loop = 1'b1;
      bus.cfg_len = 5'd2;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int n = 0; n <= 17; n++) begin
         int m;
         m = (n > 16) ? 16 : n;
         if (n == 12) loop = 1'b0;
         chk("loop_sig", 32'(bus.sig_out),
             32'((m >= 2) && ((((m / 2) - 1) % 2) == 0)));
         chk("loop_busy", 32'(bus.busy), 32'(n < 16));
         chk("loop_done", 32'(bus.done), 32'(n == 16));
         tick();
      end
      sig_m = 4'h0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
